// File: rtl/sb_pkg.sv
// Shared opcodes, constants and FSM state types for the SB 2.0 DSP block.
package sb_pkg;

    localparam logic [7:0] SB_CMD_DAC     = 8'h10;
    localparam logic [7:0] SB_CMD_DMA8    = 8'h14;
    localparam logic [7:0] SB_CMD_DMA8_AI = 8'h1C;
    localparam logic [7:0] SB_CMD_TC      = 8'h40;
    localparam logic [7:0] SB_CMD_BLKSZ   = 8'h48;
    localparam logic [7:0] SB_CMD_PAUSE   = 8'hD0;
    localparam logic [7:0] SB_CMD_CONT    = 8'hD4;
    localparam logic [7:0] SB_CMD_SPK_ON  = 8'hD1;
    localparam logic [7:0] SB_CMD_SPK_OFF = 8'hD3;
    localparam logic [7:0] SB_CMD_EXIT_AI = 8'hDA;
    localparam logic [7:0] SB_CMD_VER     = 8'hE1;
    localparam logic [7:0] SB_CMD_IRQ     = 8'hF2;

    localparam logic [7:0] SB_RESET_ACK = 8'hAA;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ARG1,
        C_ARG2
    } cmd_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_PACE,
        D_REQ
    } dma_state_e;

endpackage

// File: rtl/sb_rdq.sv
// Two-entry DSP read queue; pop is applied before push, clr empties it.
module sb_rdq (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       nonempty
);

    logic [7:0] e0_q, e0_d;
    logic [7:0] e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = push ? 2'd1 : 2'd0;
            e0_d  = din;
        end else begin
            if (pop && cnt_q != 2'd0) begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            // a push into a full queue is silently dropped
            if (push && cnt_d != 2'd2) begin
                if (cnt_d == 2'd0) begin
                    e0_d = din;
                end else begin
                    e1_d = din;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= 8'h00;
            e1_q  <= 8'h00;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign nonempty = (cnt_q != 2'd0);
    assign head     = nonempty ? e0_q : 8'h00;

endmodule

// File: rtl/sb_dsp_dma_ctrl.sv
// SB 2.0 DSP command sequencer and paced 8-bit playback DMA controller.
module sb_dsp_dma_ctrl
    import sb_pkg::*;
#(
    parameter int         CLKS_PER_US = 50,
    parameter logic [7:0] TC_RESET    = 8'hA6,
    parameter logic [7:0] VER_MAJ     = 8'h02,
    parameter logic [7:0] VER_MIN     = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_data,
    input  logic       rstport_wr,
    input  logic       rstport_bit,
    input  logic       rd_pop,
    input  logic       stat_rd,
    output logic [7:0] rd_data,
    output logic       rd_avail,
    input  logic       dack_n,
    input  logic       dma_stb,
    input  logic [7:0] dma_data,
    output logic       drq,
    output logic       irq,
    output logic [7:0] pcm,
    output logic       spk_on,
    output logic       dma_busy
);

    cmd_state_e cmd_q, cmd_d;
    dma_state_e dma_q, dma_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  tc_q, tc_d;
    logic [15:0] blk_q, blk_d;
    logic [7:0]  pcm_q, pcm_d;
    logic        spk_q, spk_d;
    logic        pause_q, pause_d;
    logic        exit_q, exit_d;
    logic        auto_q, auto_d;
    logic        ver_q, ver_d;
    logic        arm_q, arm_d;
    logic        irq_q, irq_d;
    logic        drq_q, drq_d;
    logic        busy_q, busy_d;
    logic [23:0] cnt_q, cnt_d;
    logic [16:0] rem_q, rem_d;

    logic        soft_rst;
    logic        start;
    logic        start_ai;
    logic [16:0] start_len;
    logic        irq_set;
    logic        q_push;
    logic [7:0]  q_din;
    logic [23:0] period;
    logic        pace_hit;

    assign soft_rst = rstport_wr && !rstport_bit && arm_q;
    assign period   = 24'(CLKS_PER_US) * (24'd256 - {16'd0, tc_q});
    assign pace_hit = (cnt_q >= period - 24'd1);

    always_comb begin
        cmd_d     = cmd_q;
        op_d      = op_q;
        lo_d      = lo_q;
        tc_d      = tc_q;
        blk_d     = blk_q;
        spk_d     = spk_q;
        pause_d   = pause_q;
        exit_d    = exit_q;
        ver_d     = 1'b0;
        arm_d     = rstport_wr ? rstport_bit : arm_q;
        start     = 1'b0;
        start_ai  = 1'b0;
        start_len = 17'd0;
        irq_set   = 1'b0;
        q_push    = ver_q;
        q_din     = VER_MIN;
        pcm_d     = pcm_q;

        if (cmd_wr) begin
            case (cmd_q)
                C_IDLE: begin
                    op_d = cmd_data;
                    case (cmd_data)
                        SB_CMD_DAC, SB_CMD_DMA8,
                        SB_CMD_TC, SB_CMD_BLKSZ: cmd_d = C_ARG1;
                        SB_CMD_DMA8_AI: begin
                            start    = 1'b1;
                            start_ai = 1'b1;
                        end
                        SB_CMD_PAUSE:   pause_d = 1'b1;
                        SB_CMD_CONT:    pause_d = 1'b0;
                        SB_CMD_SPK_ON:  spk_d   = 1'b1;
                        SB_CMD_SPK_OFF: spk_d   = 1'b0;
                        SB_CMD_EXIT_AI: exit_d  = 1'b1;
                        SB_CMD_VER: begin
                            q_push = 1'b1;
                            q_din  = VER_MAJ;
                            ver_d  = 1'b1;
                        end
                        SB_CMD_IRQ:     irq_set = 1'b1;
                        default: ;
                    endcase
                end
                C_ARG1: begin
                    cmd_d = C_IDLE;
                    case (op_q)
                        SB_CMD_DAC: pcm_d = cmd_data;
                        SB_CMD_TC:  tc_d  = cmd_data;
                        default: begin
                            lo_d  = cmd_data;
                            cmd_d = C_ARG2;
                        end
                    endcase
                end
                C_ARG2: begin
                    cmd_d = C_IDLE;
                    if (op_q == SB_CMD_DMA8) begin
                        start     = 1'b1;
                        start_len = {1'b0, cmd_data, lo_q} + 17'd1;
                    end else begin
                        blk_d = {cmd_data, lo_q};
                    end
                end
                default: cmd_d = C_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_d  = dma_q;
        drq_d  = drq_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        auto_d = auto_q;
        if (start) begin
            rem_d  = start_ai ? {1'b0, blk_q} + 17'd1 : start_len;
            auto_d = start_ai;
            cnt_d  = 24'd0;
            drq_d  = 1'b0;
            busy_d = 1'b1;
            dma_d  = D_PACE;
        end else begin
            case (dma_q)
                D_PACE: begin
                    if (!pause_q) begin
                        if (pace_hit) begin
                            if (dack_n) begin
                                drq_d = 1'b1;
                                dma_d = D_REQ;
                            end
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end
                end
                D_REQ: begin
                    if (dma_stb) begin
                        drq_d = 1'b0;
                        cnt_d = 24'd0;
                        rem_d = rem_q - 17'd1;
                        dma_d = D_PACE;
                        if (rem_q == 17'd1) begin
                            if (auto_q && !exit_q) begin
                                rem_d = {1'b0, blk_q} + 17'd1;
                            end else begin
                                dma_d  = D_IDLE;
                                busy_d = 1'b0;
                                auto_d = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // DMA data and end-of-block irq override command-side writes
    logic       dma_xfer;
    logic       dma_eob;
    logic [7:0] pcm_n;
    logic       irq_n;

    assign dma_xfer = !start && dma_q == D_REQ && dma_stb;
    assign dma_eob  = dma_xfer && rem_q == 17'd1;
    assign pcm_n    = dma_xfer ? dma_data : pcm_d;
    assign irq_n    = irq_set || dma_eob || (irq_q && !stat_rd);

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            cmd_q   <= C_IDLE;
            dma_q   <= D_IDLE;
            op_q    <= 8'h00;
            lo_q    <= 8'h00;
            tc_q    <= TC_RESET;
            blk_q   <= 16'h07FF;
            pcm_q   <= 8'h80;
            spk_q   <= 1'b0;
            pause_q <= 1'b0;
            exit_q  <= 1'b0;
            auto_q  <= 1'b0;
            ver_q   <= 1'b0;
            arm_q   <= 1'b0;
            irq_q   <= 1'b0;
            drq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 24'd0;
            rem_q   <= 17'd0;
        end else begin
            cmd_q   <= cmd_d;
            dma_q   <= dma_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            tc_q    <= tc_d;
            blk_q   <= blk_d;
            pcm_q   <= pcm_n;
            spk_q   <= spk_d;
            pause_q <= pause_d;
            exit_q  <= start ? 1'b0 : exit_d;
            auto_q  <= auto_d;
            ver_q   <= ver_d;
            arm_q   <= arm_d;
            irq_q   <= irq_n;
            drq_q   <= drq_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    sb_rdq u_rdq (
        .clk      (clk),
        .rst      (rst),
        .clr      (soft_rst),
        .push     (soft_rst || q_push),
        .din      (soft_rst ? SB_RESET_ACK : q_din),
        .pop      (rd_pop),
        .head     (rd_data),
        .nonempty (rd_avail)
    );

    assign drq      = drq_q;
    assign irq      = irq_q;
    assign pcm      = pcm_q;
    assign spk_on   = spk_q;
    assign dma_busy = busy_q;

endmodule

// File: tb/tb_sb_dsp_dma_ctrl.sv
// Directed bench: per-cycle vector table plus DMA pacing/pause/reset sequences.
module tb_sb_dsp_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rstport_wr = 1'b0;
    logic       rstport_bit = 1'b0;
    logic       rd_pop = 1'b0;
    logic       stat_rd = 1'b0;
    logic [7:0] rd_data;
    logic       rd_avail;
    logic       dack_n = 1'b1;
    logic       dma_stb = 1'b0;
    logic [7:0] dma_data = 8'h00;
    logic       drq;
    logic       irq;
    logic [7:0] pcm;
    logic       spk_on;
    logic       dma_busy;

    int n_pass = 0;
    int n_total = 0;

    sb_dsp_dma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_wr      (cmd_wr),
        .cmd_data    (cmd_data),
        .rstport_wr  (rstport_wr),
        .rstport_bit (rstport_bit),
        .rd_pop      (rd_pop),
        .stat_rd     (stat_rd),
        .rd_data     (rd_data),
        .rd_avail    (rd_avail),
        .dack_n      (dack_n),
        .dma_stb     (dma_stb),
        .dma_data    (dma_data),
        .drq         (drq),
        .irq         (irq),
        .pcm         (pcm),
        .spk_on      (spk_on),
        .dma_busy    (dma_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cw;
        logic [7:0] cd;
        logic       rw;
        logic       rb;
        logic       pop;
        logic       sr;
        logic [7:0] e_rd;
        logic       e_av;
        logic       e_irq;
        logic [7:0] e_pcm;
        logic       e_spk;
        string      name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_wr   = 1'b1;
        cmd_data = b;
        step();
        cmd_wr   = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b);
        dack_n   = 1'b0;
        dma_stb  = 1'b1;
        dma_data = b;
        step();
        dma_stb  = 1'b0;
        dack_n   = 1'b1;
    endtask

    task automatic wait_drq(input int maxc, output int n);
        n = 0;
        while (!drq && n < maxc) begin
            step();
            n++;
        end
    endtask

    task automatic ack_irq();
        stat_rd = 1'b1;
        step();
        stat_rd = 1'b0;
    endtask

    initial begin
        int n;
        int hi;

        // cw cd rw rb pop sr | rd av irq pcm spk
        vt.push_back('{0,8'h00,1,1,0,0, 8'h00,0,0,8'h80,0,"arm"});
        vt.push_back('{0,8'h00,1,0,0,0, 8'hAA,1,0,8'h80,0,"soft_rst"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h00,0,0,8'h80,0,"pop_ack"});
        vt.push_back('{0,8'h00,1,0,0,0, 8'h00,0,0,8'h80,0,"unarmed0"});
        vt.push_back('{1,8'hE1,0,0,0,0, 8'h02,1,0,8'h80,0,"ver1"});
        vt.push_back('{0,8'h00,0,0,0,0, 8'h02,1,0,8'h80,0,"ver2"});
        vt.push_back('{1,8'hE1,0,0,0,0, 8'h02,1,0,8'h80,0,"ver_full"});
        vt.push_back('{0,8'h00,0,0,0,0, 8'h02,1,0,8'h80,0,"ver_drop"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h01,1,0,8'h80,0,"pop_maj"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h00,0,0,8'h80,0,"pop_min"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h00,0,0,8'h80,0,"pop_empty"});
        vt.push_back('{1,8'hD1,0,0,0,0, 8'h00,0,0,8'h80,1,"spk_on"});
        vt.push_back('{1,8'hD3,0,0,0,0, 8'h00,0,0,8'h80,0,"spk_off"});
        vt.push_back('{1,8'h10,0,0,0,0, 8'h00,0,0,8'h80,0,"dac_op"});
        vt.push_back('{1,8'h5A,0,0,0,0, 8'h00,0,0,8'h5A,0,"dac_val"});
        vt.push_back('{1,8'hF2,0,0,0,0, 8'h00,0,1,8'h5A,0,"irq_set"});
        vt.push_back('{0,8'h00,0,0,0,1, 8'h00,0,0,8'h5A,0,"irq_ack"});
        vt.push_back('{1,8'hF2,0,0,0,1, 8'h00,0,1,8'h5A,0,"irq_race"});
        vt.push_back('{0,8'h00,0,0,0,1, 8'h00,0,0,8'h5A,0,"irq_ack2"});
        vt.push_back('{1,8'h99,0,0,0,0, 8'h00,0,0,8'h5A,0,"bad_op"});
        vt.push_back('{1,8'hD1,0,0,0,0, 8'h00,0,0,8'h5A,1,"after_bad"});
        vt.push_back('{1,8'hD3,0,0,0,0, 8'h00,0,0,8'h5A,0,"spk_off2"});
        vt.push_back('{1,8'hE1,0,0,0,0, 8'h02,1,0,8'h5A,0,"ver_a"});
        vt.push_back('{0,8'h00,0,0,0,0, 8'h02,1,0,8'h5A,0,"ver_b"});
        vt.push_back('{1,8'hE1,0,0,1,0, 8'h01,1,0,8'h5A,0,"push_pop"});
        vt.push_back('{0,8'h00,0,0,0,0, 8'h01,1,0,8'h5A,0,"pend_drop"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h02,1,0,8'h5A,0,"pop_x"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h00,0,0,8'h5A,0,"pop_y"});
        vt.push_back('{1,8'hD1,0,0,0,0, 8'h00,0,0,8'h5A,1,"spk_on2"});
        vt.push_back('{0,8'h00,1,1,0,0, 8'h00,0,0,8'h5A,1,"arm2"});
        vt.push_back('{0,8'h00,1,0,0,0, 8'hAA,1,0,8'h80,0,"soft_rst2"});
        vt.push_back('{0,8'h00,0,0,1,0, 8'h00,0,0,8'h80,0,"pop_ack2"});

        step();
        step();
        rst = 1'b0;
        chk("reset_state",
            32'({rd_data, rd_avail, drq, irq, pcm, spk_on, dma_busy}),
            32'({8'h00, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0}));

        foreach (vt[i]) begin
            cmd_wr      = vt[i].cw;
            cmd_data    = vt[i].cd;
            rstport_wr  = vt[i].rw;
            rstport_bit = vt[i].rb;
            rd_pop      = vt[i].pop;
            stat_rd     = vt[i].sr;
            step();
            chk(vt[i].name,
                32'({rd_data, rd_avail, irq, pcm, spk_on, dma_busy, drq}),
                32'({vt[i].e_rd, vt[i].e_av, vt[i].e_irq, vt[i].e_pcm,
                     vt[i].e_spk, 2'b00}));
        end
        cmd_wr = 1'b0;
        rstport_wr = 1'b0;
        rd_pop = 1'b0;
        stat_rd = 1'b0;

        // single-cycle DMA, 3 bytes at TC=FFh (50-cycle pace)
        send(8'h40);
        send(8'hFF);
        send(8'h14);
        send(8'h02);
        send(8'h00);
        chk("sc_busy", 32'(dma_busy), 32'd1);
        wait_drq(20000, n);
        chk("sc_pace1", 32'(n), 32'd50);
        xfer(8'h10);
        chk("sc_b1", 32'({pcm, drq, irq, dma_busy}),
            32'({8'h10, 1'b0, 1'b0, 1'b1}));
        wait_drq(20000, n);
        chk("sc_pace2", 32'(n), 32'd50);
        xfer(8'h20);
        chk("sc_b2", 32'({pcm, irq}), 32'({8'h20, 1'b0}));
        wait_drq(20000, n);
        chk("sc_pace3", 32'(n), 32'd50);
        xfer(8'h30);
        chk("sc_end", 32'({pcm, drq, irq, dma_busy}),
            32'({8'h30, 1'b0, 1'b1, 1'b0}));
        ack_irq();
        chk("sc_ack", 32'(irq), 32'd0);
        dma_stb = 1'b1;
        dma_data = 8'hEE;
        step();
        dma_stb = 1'b0;
        chk("stray_stb", 32'(pcm), 32'h30);

        // auto-init, block of 2 bytes
        send(8'h48);
        send(8'h01);
        send(8'h00);
        send(8'h1C);
        wait_drq(20000, n);
        chk("ai_pace", 32'(n), 32'd50);
        xfer(8'h41);
        chk("ai_b1", 32'({irq, dma_busy}), 32'({1'b0, 1'b1}));
        wait_drq(20000, n);
        xfer(8'h42);
        chk("ai_b2", 32'({irq, dma_busy}), 32'({1'b1, 1'b1}));
        ack_irq();
        wait_drq(20000, n);
        xfer(8'h43);
        chk("ai_b3", 32'({irq, dma_busy}), 32'({1'b0, 1'b1}));
        wait_drq(20000, n);
        xfer(8'h44);
        chk("ai_b4", 32'({pcm, irq, dma_busy}),
            32'({8'h44, 1'b1, 1'b1}));
        ack_irq();
        send(8'hDA);
        wait_drq(20000, n);
        xfer(8'h45);
        chk("ai_b5", 32'({irq, dma_busy}), 32'({1'b0, 1'b1}));
        wait_drq(20000, n);
        xfer(8'h46);
        chk("ai_exit", 32'({pcm, irq, dma_busy}),
            32'({8'h46, 1'b1, 1'b0}));
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (drq) hi++;
        end
        chk("ai_idle_drq", 32'(hi), 32'd0);
        ack_irq();

        // pause while a request is pending
        send(8'h14);
        send(8'h03);
        send(8'h00);
        wait_drq(20000, n);
        chk("pz_pace", 32'(n), 32'd50);
        send(8'hD0);
        chk("pz_drq_held", 32'(drq), 32'd1);
        xfer(8'hC1);
        chk("pz_xfer", 32'({pcm, drq}), 32'({8'hC1, 1'b0}));
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (drq) hi++;
        end
        chk("pz_frozen", 32'(hi), 32'd0);
        send(8'hD4);
        wait_drq(20000, n);
        chk("pz_resume", 32'(n), 32'd50);

        // hard reset in D_REQ with irq pending
        send(8'hF2);
        chk("rs_pre", 32'({drq, irq}), 32'({1'b1, 1'b1}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_state", 32'({drq, irq, pcm, dma_busy}),
            32'({1'b0, 1'b0, 8'h80, 1'b0}));
        xfer(8'h77);
        chk("rs_stb_ign", 32'({pcm, drq, irq, dma_busy}),
            32'({8'h80, 1'b0, 1'b0, 1'b0}));

        // reset TC of A6h gives 50*90 cycle pace
        send(8'h14);
        send(8'h00);
        send(8'h00);
        wait_drq(20000, n);
        chk("tc_reset_pace", 32'(n), 32'd4500);
        xfer(8'h5C);
        chk("tc_one_byte", 32'({pcm, irq, dma_busy}),
            32'({8'h5C, 1'b1, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sb_dsp_dma_ctrl.md
Name: sb_dsp_dma_ctrl

Overview:
- Sound Blaster 2.0 DSP command sequencer and 8-bit playback DMA controller for the ISA bridge.
- Decodes host writes to 22Ch (command/argument bytes), 226h (reset) and reads of 22Ah/22Eh.
- Paces DRQ1 from the time constant and runs the DRQ1/DACK1 handshake; data is transferred by IOW rising while DACK1 is low.
- Delivers PCM bytes to the S/PDIF mixer and raises IRQ7 at end of block.
- The parent performs ISA edge detection and address decode, and drives the 1-cycle strobes into this block.

Parameters:
- CLKS_PER_US, 50, clk cycles per microsecond; sample period = CLKS_PER_US*(256-TC).
- TC_RESET, 8'hA6, time constant after reset (90 us, ~11.1 kHz).
- VER_MAJ, 8'h02, DSP version major byte.
- VER_MIN, 8'h01, DSP version minor byte.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- cmd_wr  in  1  1-cycle strobe: host wrote 22Ch.
- cmd_data  in  8  byte written to 22Ch.
- rstport_wr  in  1  1-cycle strobe: host wrote 226h.
- rstport_bit  in  1  bit 0 of byte written to 226h.
- rd_pop  in  1  1-cycle strobe: host finished reading 22Ah.
- stat_rd  in  1  1-cycle strobe: host read 22Eh (also acknowledges IRQ).
- rd_data  out  8  byte presented on 22Ah (head of read queue, 00h if empty).
- rd_avail  out  1  22Eh bit 7: read queue non-empty.
- dack_n  in  1  synchronized DACK1, active low.
- dma_stb  in  1  1-cycle strobe: IOW rising while DACK1 low.
- dma_data  in  8  ISA data bus latched with dma_stb.
- drq  out  1  DRQ1 request level.
- irq  out  1  IRQ7 level.
- pcm  out  8  unsigned 8-bit sample to mixer.
- spk_on  out  1  speaker enable.
- dma_busy  out  1  DMA transfer active.

Behaviour:
- Reset values: rd_data=00h, rd_avail=0, drq=0, irq=0, pcm=80h, spk_on=0, dma_busy=0, TC=TC_RESET, block size=07FFh, read queue empty, both FSMs idle.
- Reset mid-transfer aborts immediately; no IRQ is raised.
- 226h host reset:
  - Writing 1 arms the sequence; a subsequent write of 0 performs a soft reset: same state as rst, except the read queue then holds AAh (rd_avail=1 on the next cycle).
  - A write of 0 without a prior 1 is ignored.
- Read queue:
  - Depth 2; rd_pop removes the head.
  - Push to a full queue drops the new byte.
  - Pop of an empty queue is ignored.
  - Simultaneous push and pop: pop first, then push.
- Command FSM states: C_IDLE, C_ARG1, C_ARG2; cmd_wr advances state.
  - 10h: next byte -> pcm (direct DAC).
  - 14h: lo, hi -> length={hi,lo}+1, 17 bits (FFFFh -> 65536); start single-cycle DMA.
  - 1Ch: start auto-init DMA using block size.
  - 40h: next byte -> TC.
  - 48h: lo, hi -> block size.
  - D0: pause. D4: continue.
  - D1: spk_on=1. D3: spk_on=0.
  - DAh: exit auto-init after the current block.
  - E1h: push VER_MAJ then VER_MIN.
  - F2h: set irq.
  - Any other opcode in C_IDLE: ignored, stay in C_IDLE.
- DMA FSM states: D_IDLE, D_PACE, D_REQ.
  - Start (14h/1Ch) from any state: load remaining, clear pace counter, go D_PACE, dma_busy=1. A restart mid-block discards the old count and deasserts drq.
  - D_PACE: counter increments each cycle unless paused. When it reaches CLKS_PER_US*(256-TC)-1 and dack_n=1, set drq=1 and go D_REQ.
  - D_REQ: on dma_stb, set drq=0, pcm<=dma_data, remaining-1, counter=0.
    - If remaining was 1: irq=1. Auto-init and not exiting: reload block size+1, go D_PACE. Otherwise go D_IDLE and dma_busy=0.
    - Else go D_PACE.
  - dma_stb outside D_REQ: ignored.
  - Pause in D_REQ: drq stays high until the pending byte transfers, then the FSM holds in D_PACE with the counter frozen.
- irq: cleared by stat_rd. If a set and stat_rd coincide, the set wins.
- spk_on=0 does not stop DMA; the mixer mutes.
- TC change takes effect on the next D_PACE comparison. Pace compare uses a 24-bit product.

Decomposition:
- Shared package sb_pkg holds:
  - opcode localparams (SB_CMD_DAC, SB_CMD_DMA8, SB_CMD_DMA8_AI, SB_CMD_TC, SB_CMD_BLKSZ, SB_CMD_PAUSE, SB_CMD_CONT, SB_CMD_SPK_ON, SB_CMD_SPK_OFF, SB_CMD_EXIT_AI, SB_CMD_VER, SB_CMD_IRQ);
  - the SB_RESET_ACK=8'hAA constant;
  - the command and DMA FSM state enums.
- One sub-module, sb_rdq: 2-entry read queue with push/pop/head/nonempty.

Test Plan:
- 226h write 1 then 0 -> rd_avail=1, rd_data=AAh; rd_pop -> rd_avail=0, rd_data=00h.
- Send E1h -> queue holds 02h then 01h; pop order 02h, 01h; a third push while full is dropped.
- Send 40h,FFh then 14h,02h,00h; answer each drq with dma_stb data 10h,20h,30h -> drq rises every 50 cycles after prior transfer; pcm=10h,20h,30h; irq=1 after third byte; dma_busy=0; stat_rd clears irq.
- Send 48h,01h,00h then 1Ch; transfer 4 bytes -> irq set after bytes 2 and 4, still busy. Send DAh; transfer 2 more bytes -> D_IDLE.
- Send D0h while drq=1 -> the pending byte transfers, drq stays 0 for 1000 cycles. Send D4h -> drq returns 50*(256-TC) cycles later.
- Assert rst during D_REQ -> next cycle drq=0, irq=0, pcm=80h, dma_busy=0; a subsequent dma_stb is ignored.
